// File: rtl/cc_transictrl.sv
// Transition display controller: alternates the NADA/TRANSI mux select through
// N SHOW/HIDE pairs of P cycles each, then pulses done for one cycle.
module cc_transictrl #(
  parameter int TRANSICTRL_PERIODWIDTH = 8,
  parameter int TRANSICTRL_BLINKWIDTH  = 4
) (
  input  logic                              CC_TRANSICTRL_CLOCK_50,
  input  logic                              CC_TRANSICTRL_RESET_InHigh,
  input  logic                              CC_TRANSICTRL_start_InHigh,
  input  logic                              CC_TRANSICTRL_abort_InHigh,
  input  logic [TRANSICTRL_PERIODWIDTH-1:0] CC_TRANSICTRL_period_InBUS,
  input  logic [TRANSICTRL_BLINKWIDTH-1:0]  CC_TRANSICTRL_blinks_InBUS,
  output logic                              CC_TRANSICTRL_select_OutBUS,
  output logic                              CC_TRANSICTRL_busy_OutHigh,
  output logic                              CC_TRANSICTRL_done_OutHigh,
  output logic [TRANSICTRL_BLINKWIDTH-1:0]  CC_TRANSICTRL_blinkidx_OutBUS
);

  localparam int PW = TRANSICTRL_PERIODWIDTH;
  localparam int BW = TRANSICTRL_BLINKWIDTH;
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [BW-1:0] B_ONE = BW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HIDE = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pl_q, pl_d;
  logic [BW-1:0] nl_q, nl_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [BW:0]   bidx_inc;
  logic          phase_end;

  assign bidx_inc  = {1'b0, bidx_q} + {1'b0, B_ONE};
  assign phase_end = (cnt_q == pl_q - P_ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pl_d    = pl_q;
    nl_d    = nl_q;
    bidx_d  = bidx_q;
    case (state_q)
      IDLE: begin
        if (CC_TRANSICTRL_start_InHigh && !CC_TRANSICTRL_abort_InHigh) begin
          pl_d    = (CC_TRANSICTRL_period_InBUS == '0) ? P_ONE : CC_TRANSICTRL_period_InBUS;
          nl_d    = CC_TRANSICTRL_blinks_InBUS;
          cnt_d   = '0;
          bidx_d  = '0;
          state_d = (CC_TRANSICTRL_blinks_InBUS == '0) ? DONE : SHOW;
        end
      end
      SHOW: begin
        if (CC_TRANSICTRL_abort_InHigh) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (phase_end) begin
          state_d = HIDE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + P_ONE;
        end
      end
      HIDE: begin
        if (CC_TRANSICTRL_abort_InHigh) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (phase_end) begin
          cnt_d = '0;
          // Saturate at Nl; the pair just finished decides whether another follows.
          if (bidx_q != nl_q) bidx_d = bidx_q + B_ONE;
          state_d = (bidx_inc < {1'b0, nl_q}) ? SHOW : DONE;
        end else begin
          cnt_d = cnt_q + P_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CC_TRANSICTRL_CLOCK_50) begin
    if (CC_TRANSICTRL_RESET_InHigh) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pl_q    <= '0;
      nl_q    <= '0;
      bidx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pl_q    <= pl_d;
      nl_q    <= nl_d;
      bidx_q  <= bidx_d;
    end
  end

  // Outputs decode registered state only, so no input reaches them combinationally.
  assign CC_TRANSICTRL_select_OutBUS   = (state_q == SHOW);
  assign CC_TRANSICTRL_busy_OutHigh    = (state_q != IDLE);
  assign CC_TRANSICTRL_done_OutHigh    = (state_q == DONE);
  assign CC_TRANSICTRL_blinkidx_OutBUS = bidx_q;

endmodule

// File: tb/tb_cc_transictrl.sv
// Randomized and directed bench for cc_transictrl against an offset-based
// reference model of the SHOW/HIDE sequence.
module tb_cc_transictrl;

  localparam int PW = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [PW-1:0] period;
  logic [BW-1:0] blinks;
  logic          sel, busy, done;
  logic [BW-1:0] bidx;

  int errors = 0;
  int checks = 0;

  // Model: a running sequence is described by its offset from the first busy cycle.
  bit m_act;
  int m_off, m_P, m_N, m_bidx;

  cc_transictrl #(
    .TRANSICTRL_PERIODWIDTH(PW),
    .TRANSICTRL_BLINKWIDTH (BW)
  ) dut (
    .CC_TRANSICTRL_CLOCK_50       (clk),
    .CC_TRANSICTRL_RESET_InHigh   (rst),
    .CC_TRANSICTRL_start_InHigh   (start),
    .CC_TRANSICTRL_abort_InHigh   (abort),
    .CC_TRANSICTRL_period_InBUS   (period),
    .CC_TRANSICTRL_blinks_InBUS   (blinks),
    .CC_TRANSICTRL_select_OutBUS  (sel),
    .CC_TRANSICTRL_busy_OutHigh   (busy),
    .CC_TRANSICTRL_done_OutHigh   (done),
    .CC_TRANSICTRL_blinkidx_OutBUS(bidx)
  );

  always #5 clk = ~clk;

  wire [BW+2:0] obs = {sel, busy, done, bidx};

  function automatic logic [BW+2:0] exp_vec();
    logic s;
    if (!m_act) return {3'b000, BW'(m_bidx)};
    if (m_off < 2 * m_P * m_N) begin
      s = ((m_off % (2 * m_P)) < m_P);
      return {s, 2'b10, BW'(m_off / (2 * m_P))};
    end
    return {3'b011, BW'(m_N)};
  endfunction

  task automatic model_update();
    if (rst) begin
      m_act = 0; m_bidx = 0; m_off = 0; m_P = 0; m_N = 0;
    end else if (!m_act) begin
      if (start && !abort) begin
        m_act = 1; m_off = 0; m_bidx = 0;
        m_P = (period == 0) ? 1 : int'(period);
        m_N = int'(blinks);
      end
    end else if (m_off < 2 * m_P * m_N) begin
      if (abort) begin
        m_act = 0; m_bidx = m_off / (2 * m_P);
      end else begin
        m_off++;
      end
    end else begin
      m_act = 0; m_bidx = m_N;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; abort = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 1; abort = 0; period = 8'd3; blinks = 4'd2;
    tick(); tick();
    checks++;
    if (obs !== {3'b000, {BW{1'b0}}}) begin
      errors++; $display("FAIL reset: got %b want %b", obs, {3'b000, {BW{1'b0}}});
    end
    idle_inputs();
  endtask

  task automatic test_basic();
    int busy_cnt = 0;
    logic [11:0] sel_seq = '0;
    period = 8'd3; blinks = 4'd2; start = 1;
    tick();
    start = 0; period = 8'd7; blinks = 4'd9;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL basic cyc%0d: got %b want %b", i, obs, exp_vec());
      end
      if (busy) busy_cnt++;
      if (i < 12) sel_seq[11 - i] = sel;
      tick();
    end
    checks++;
    if (busy_cnt !== 13) begin
      errors++; $display("FAIL basic_busy_len: got %0d want 13", busy_cnt);
    end
    checks++;
    if (sel_seq !== 12'b111000111000) begin
      errors++; $display("FAIL basic_select_pattern: got %b want 111000111000", sel_seq);
    end
    checks++;
    if (bidx !== 4'd2) begin
      errors++; $display("FAIL basic_final_bidx: got %0d want 2", bidx);
    end
  endtask

  task automatic test_zero_cases();
    int busy_cnt;
    // N=0 then P=0
    for (int k = 0; k < 2; k++) begin
      busy_cnt = 0;
      period = (k == 0) ? 8'd5 : 8'd0;
      blinks = (k == 0) ? 4'd0 : 4'd1;
      start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs !== exp_vec()) begin
          errors++; $display("FAIL zero%0d cyc%0d: got %b want %b", k, i, obs, exp_vec());
        end
        if (busy) busy_cnt++;
        tick();
      end
      checks++;
      if (busy_cnt !== ((k == 0) ? 1 : 3)) begin
        errors++; $display("FAIL zero%0d_busy_len: got %0d want %0d", k, busy_cnt, (k == 0) ? 1 : 3);
      end
    end
  endtask

  task automatic test_abort();
    period = 8'd4; blinks = 4'd3; start = 1;
    tick();
    start = 0;
    // 2nd SHOW cycle of blink 1 is offset 2P+1 = 9
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL abort_pre cyc%0d: got %b want %b", i, obs, exp_vec());
      end
      tick();
    end
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (obs !== {3'b000, 4'd1}) begin
      errors++; $display("FAIL abort_result: got %b want %b", obs, {3'b000, 4'd1});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || obs !== exp_vec()) begin
        errors++; $display("FAIL abort_after cyc%0d: got %b want %b", i, obs, exp_vec());
      end
    end
    // start with abort in IDLE stays idle; abort during DONE is ignored
    start = 1; abort = 1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_abort_idle: busy got %b want 0", busy);
    end
    abort = 0; blinks = 4'd0;
    tick();
    start = 0; abort = 1;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL abort_in_done: done got %b want 1", done);
    end
    tick();
    abort = 0;
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL abort_in_done_after: got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    int first_show = -1;
    int done_at = -1;
    period = 8'd2; blinks = 4'd1; start = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 8) begin period = 8'd9; blinks = 4'd5; end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL restart cyc%0d: got %b want %b", i, obs, exp_vec());
      end
      if (done && done_at < 0) done_at = i;
      if (done_at >= 0 && i == done_at + 2) first_show = sel;
    end
    checks++;
    if (first_show !== 1) begin
      errors++; $display("FAIL restart_gap: select two cycles after done got %0d want 1", first_show);
    end
    start = 0;
    while (busy) tick();
    // start pulsed mid-run must not alter the timing
    period = 8'd3; blinks = 4'd2; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 14; i++) begin
      start = (i == 3 || i == 7);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL midstart cyc%0d: got %b want %b", i, obs, exp_vec());
      end
      tick();
    end
    start = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    period = 8'd3; blinks = 4'd2; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (busy !== 1'b1 || sel !== 1'b0) begin
      errors++; $display("FAIL reset_mid_in_hide: got %b want busy HIDE", obs);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (obs !== {3'b000, {BW{1'b0}}}) begin
      errors++; $display("FAIL reset_mid: got %b want %b", obs, {3'b000, {BW{1'b0}}});
    end
    start = 1; period = 8'd1; blinks = 4'd1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL reset_restart cyc%0d: got %b want %b", i, obs, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      abort  = ($urandom_range(0, 24) == 0);
      start  = ($urandom_range(0, 2) == 0);
      period = PW'($urandom_range(0, 4));
      blinks = BW'($urandom_range(0, 3));
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random cyc%0d: got %b want %b", i, obs, exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    m_act = 0; m_off = 0; m_P = 0; m_N = 0; m_bidx = 0;
    idle_inputs(); period = '0; blinks = '0;
    test_reset();
    test_basic();
    test_zero_cases();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
